// File: rtl/dense_weight_sink_pkg.sv
// Shared definitions for the dense_weight_sink block.
//   state_e : load FSM states (IDLE, LOAD, DONE)
//   CSUM_W  : width of the running word checksum output
package dense_weight_sink_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned CSUM_W = 32;

endpackage

// File: rtl/dense_weight_sink_ram.sv
// Simple dual-port weight RAM for dense_weight_sink.
//   Write port : we / waddr / wdata, one word per clock.
//   Read port  : raddr / ce -> rdata, two ce-gated register stages
//                (stage 0 captures the array, stage 1 drives rdata).
//   Reads are read-first against a same-cycle write; addresses at or
//   beyond DEPTH read as zero. rst_n clears only the read pipeline,
//   never the array contents.
module dense_weight_sink_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ce,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = DEPTH;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] stage0_q, stage0_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              wr_ok;
  logic              rd_hit;

  assign wr_ok  = we && (32'(waddr) < DEPTH_U);
  assign rd_hit = (32'(raddr) < DEPTH_U);

  // Array has no reset so a reset never wipes loaded weights.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  // Stage 0 samples the array before the same-edge write lands,
  // which gives read-first behaviour.
  always_comb begin
    stage0_d = stage0_q;
    q_d      = q_q;
    if (ce) begin
      stage0_d = rd_hit ? mem_q[raddr[IDX_W-1:0]] : '0;
      q_d      = stage0_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage0_q <= '0;
      q_q      <= '0;
    end else begin
      stage0_q <= stage0_d;
      q_q      <= q_d;
    end
  end

  assign rdata = q_q;

endmodule

// File: rtl/dense_weight_sink.sv
// dense_weight_sink: run-time weight loader feeding linear layers.
// Accepts a valid/ready stream of PAR-lane weight beats, packs
// BEATS_PER_WORD beats into one WORD_LANES-wide word (lane 0 of beat 0
// in the LSBs) and writes MEM_DEPTH words into an internal RAM, which is
// read back through the same 2-cycle addr0/ce0/q0 port the weight ROM
// sources expose.
// Ports:
//   clk, rst (async, active-low)
//   start               : arm / re-arm a load (restarts from word 0)
//   data_in[PAR], data_in_valid, data_in_ready : beat stream
//   load_done           : all MEM_DEPTH words written
//   words_loaded        : complete words written in the current load
//   addr0, ce0 -> q0    : 2-stage read port
//   checksum            : running 32-bit chunk sum of written words
// Optional feature: define DENSE_WEIGHT_SINK_CHECKSUM_EN to build the
// checksum accumulator; otherwise checksum is tied to zero.
module dense_weight_sink
  import dense_weight_sink_pkg::*;
#(
  parameter int WEIGHT_PRECISION_0       = 16,
  parameter int WEIGHT_PARALLELISM_DIM_0 = 4,
  parameter int WORD_LANES               = 8,
  parameter int MEM_DEPTH                = 4,
  parameter int BEATS_PER_WORD           = WORD_LANES / WEIGHT_PARALLELISM_DIM_0,
  parameter int ADDR_WIDTH               = $clog2(MEM_DEPTH) + 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [WEIGHT_PRECISION_0-1:0]              data_in [WEIGHT_PARALLELISM_DIM_0],
  input  logic                                       data_in_valid,
  output logic                                       data_in_ready,
  output logic                                       load_done,
  output logic [ADDR_WIDTH-1:0]                      words_loaded,
  input  logic [ADDR_WIDTH-1:0]                      addr0,
  input  logic                                       ce0,
  output logic [WEIGHT_PRECISION_0*WORD_LANES-1:0]   q0,
  output logic [CSUM_W-1:0]                          checksum
);

  localparam int unsigned P      = WEIGHT_PRECISION_0;
  localparam int unsigned PAR    = WEIGHT_PARALLELISM_DIM_0;
  localparam int unsigned WORD_W = WEIGHT_PRECISION_0 * WORD_LANES;
  localparam int          BEAT_W = (BEATS_PER_WORD > 1) ? $clog2(BEATS_PER_WORD) : 1;

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS_PER_WORD - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic [ADDR_WIDTH-1:0]   words_loaded_q, words_loaded_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [WORD_W-1:0]       pack_q, pack_d;

  logic [WORD_W-1:0]       merged;
  logic                    accept;
  logic                    wr_en;
  logic                    enter_load;

  // ready_q is only ever high in LOAD, so it also qualifies the state.
  assign accept = data_in_valid && ready_q;

  // Pack register with the current beat dropped into its lane slot;
  // this is the word written back on the final beat.
  always_comb begin
    merged = pack_q;
    for (int unsigned j = 0; j < PAR; j++) begin
      merged[P*(32'(beat_cnt_q)*PAR + j) +: P] = data_in[j];
    end
  end

  always_comb begin
    state_d        = state_q;
    ready_d        = ready_q;
    done_d         = done_q;
    words_loaded_d = words_loaded_q;
    beat_cnt_d     = beat_cnt_q;
    pack_d         = pack_q;
    wr_en          = 1'b0;
    enter_load     = 1'b0;

    // start from any state (re)enters LOAD and takes priority over a
    // beat accepted in the same cycle.
    if (start) begin
      enter_load = 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            if (beat_cnt_q == LAST_BEAT) begin
              wr_en          = 1'b1;
              words_loaded_d = words_loaded_q + 1'b1;
              beat_cnt_d     = '0;
              pack_d         = '0;
              if (words_loaded_q == LAST_WORD) begin
                state_d = DONE;
                ready_d = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
              pack_d     = merged;
            end
          end
        end
        default: begin
        end
      endcase
    end

    if (enter_load) begin
      state_d        = LOAD;
      ready_d        = 1'b1;
      done_d         = 1'b0;
      words_loaded_d = '0;
      beat_cnt_d     = '0;
      pack_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      ready_q        <= 1'b0;
      done_q         <= 1'b0;
      words_loaded_q <= '0;
      beat_cnt_q     <= '0;
      pack_q         <= '0;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      done_q         <= done_d;
      words_loaded_q <= words_loaded_d;
      beat_cnt_q     <= beat_cnt_d;
      pack_q         <= pack_d;
    end
  end

  assign data_in_ready = ready_q;
  assign load_done     = done_q;
  assign words_loaded  = words_loaded_q;

`ifdef DENSE_WEIGHT_SINK_CHECKSUM_EN
  localparam int unsigned NCHUNK = (WORD_W + CSUM_W - 1) / CSUM_W;

  logic [NCHUNK*CSUM_W-1:0] padded;
  logic [CSUM_W-1:0]        word_sum;
  logic [CSUM_W-1:0]        checksum_q, checksum_d;

  always_comb begin
    padded             = '0;
    padded[WORD_W-1:0] = merged;
    word_sum           = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      word_sum = word_sum + padded[i*CSUM_W +: CSUM_W];
    end
  end

  always_comb begin
    checksum_d = checksum_q;
    if (enter_load) begin
      checksum_d = '0;
    end else if (wr_en) begin
      checksum_d = checksum_q + word_sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  dense_weight_sink_ram #(
    .DATA_W (WEIGHT_PRECISION_0 * WORD_LANES),
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst),
    .we    (wr_en),
    .waddr (words_loaded_q),
    .wdata (merged),
    .ce    (ce0),
    .raddr (addr0),
    .rdata (q0)
  );

endmodule

// File: tb/tb_dense_weight_sink.sv
module tb_dense_weight_sink;

  logic         clk;
  logic         rst;
  logic         start;
  logic [15:0]  data_in [4];
  logic         data_in_valid;
  logic         data_in_ready;
  logic         load_done;
  logic [2:0]   words_loaded;
  logic [2:0]   addr0;
  logic         ce0;
  logic [127:0] q0;
  logic [31:0]  checksum;

  int n_cmp;
  int n_err;

  dense_weight_sink #(
    .WEIGHT_PRECISION_0       (16),
    .WEIGHT_PARALLELISM_DIM_0 (4),
    .WORD_LANES               (8),
    .MEM_DEPTH                (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .load_done     (load_done),
    .words_loaded  (words_loaded),
    .addr0         (addr0),
    .ce0           (ce0),
    .q0            (q0),
    .checksum      (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word k of a load whose first element is base: lane i = base + 8k + i.
  function automatic logic [127:0] exp_word(input int base, input int k);
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[16*i +: 16] = 16'(base + 8*k + i);
    return w;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends beats first..first+count-1 of a stream starting at base.
  task automatic send_beats(input int base, input int first, input int count, input bit bubbles);
    bit acc;
    int guard;
    for (int b = first; b < first + count; b++) begin
      if (bubbles && ($urandom_range(0, 1) == 0)) begin
        data_in_valid = 1'b0;
        tick();
      end
      for (int j = 0; j < 4; j++) data_in[j] = 16'(base + 4*b + j);
      data_in_valid = 1'b1;
      guard = 0;
      acc   = 1'b0;
      while (!acc) begin
        acc = data_in_ready;
        tick();
        if (!acc) begin
          guard++;
          if (guard > 50) begin
            check("ready_timeout", {127'd0, data_in_ready}, 128'd1);
            acc = 1'b1;
          end
        end
      end
      data_in_valid = 1'b0;
    end
  endtask

  task automatic read_word(input int a, output logic [127:0] val);
    addr0 = 3'(a);
    ce0   = 1'b1;
    tick();
    tick();
    ce0 = 1'b0;
    val = q0;
  endtask

  task automatic check_ram(input string tag, input int base);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) begin
      read_word(k, v);
      check($sformatf("%s_w%0d", tag, k), v, exp_word(base, k));
    end
  endtask

  logic [127:0] rv;
  logic [31:0]  exp_csum;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    start = 1'b0;
    data_in_valid = 1'b0;
    for (int j = 0; j < 4; j++) data_in[j] = '0;
    addr0 = '0;
    ce0 = 1'b0;
`ifdef DENSE_WEIGHT_SINK_CHECKSUM_EN
    exp_csum = 32'h0100_00F0;
`else
    exp_csum = 32'h0;
`endif

    // Reset state
    tick(); tick();
    rst = 1'b1;
    tick();
    check("rst_ready", {127'd0, data_in_ready}, 128'd0);
    check("rst_done", {127'd0, load_done}, 128'd0);
    check("rst_words", {125'd0, words_loaded}, 128'd0);
    check("rst_q0", q0, 128'd0);
    check("rst_csum", {96'd0, checksum}, 128'd0);

    // Nominal load of 0..31, valid held high
    pulse_start();
    check("nom_ready", {127'd0, data_in_ready}, 128'd1);
    for (int w = 0; w < 4; w++) begin
      send_beats(0, 2*w, 2, 1'b0);
      check($sformatf("nom_words%0d", w), {125'd0, words_loaded}, 128'(w + 1));
      if (w < 3) check($sformatf("nom_notdone%0d", w), {127'd0, load_done}, 128'd0);
    end
    check("nom_done", {127'd0, load_done}, 128'd1);
    check("nom_ready_done", {127'd0, data_in_ready}, 128'd0);
    check("nom_csum", {96'd0, checksum}, {96'd0, exp_csum});
    check_ram("nom", 0);
    check("nom_csum_held", {96'd0, checksum}, {96'd0, exp_csum});

    // Read edge cases: out of range, then ce0 freeze
    read_word(4, rv);
    check("oor_q0", rv, 128'd0);
    addr0 = 3'd1;
    ce0 = 1'b1;
    tick();
    ce0 = 1'b0;
    addr0 = 3'd2;
    tick(); tick();
    check("ce_hold_q0", q0, 128'd0);
    ce0 = 1'b1;
    tick();
    ce0 = 1'b0;
    check("ce_resume_q0", q0, exp_word(0, 1));

    // Restart mid-load; start coincides with a beat that must be dropped
    pulse_start();
    send_beats(0, 0, 3, 1'b0);
    check("rs_words_pre", {125'd0, words_loaded}, 128'd1);
    for (int j = 0; j < 4; j++) data_in[j] = 16'hEEEE;
    data_in_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    data_in_valid = 1'b0;
    check("rs_words_clr", {125'd0, words_loaded}, 128'd0);
    check("rs_ready", {127'd0, data_in_ready}, 128'd1);
    for (int w = 0; w < 4; w++) begin
      send_beats(100, 2*w, 2, 1'b0);
      check($sformatf("rs_words%0d", w), {125'd0, words_loaded}, 128'(w + 1));
    end
    check("rs_done", {127'd0, load_done}, 128'd1);
    check_ram("rs", 100);

    // Bubbles on valid, plus a same-address read during the word 0 write
    pulse_start();
    addr0 = 3'd0;
    ce0 = 1'b1;
    send_beats(0, 0, 2, 1'b1);
    tick();
    check("rf_old_q0", q0, exp_word(100, 0));
    tick();
    check("rf_new_q0", q0, exp_word(0, 0));
    ce0 = 1'b0;
    send_beats(0, 2, 6, 1'b1);
    check("bub_done", {127'd0, load_done}, 128'd1);
    check("bub_words", {125'd0, words_loaded}, 128'd4);
    check("bub_ready_done", {127'd0, data_in_ready}, 128'd0);
    check_ram("bub", 0);

    // Reset mid-load after word 1 is written
    pulse_start();
    send_beats(100, 0, 4, 1'b0);
    check("rm_words", {125'd0, words_loaded}, 128'd2);
    read_word(0, rv);
    check("rm_q0_pre", q0, exp_word(100, 0));
    #2;
    rst = 1'b0;
    #1;
    check("rm_ready", {127'd0, data_in_ready}, 128'd0);
    check("rm_done", {127'd0, load_done}, 128'd0);
    check("rm_words0", {125'd0, words_loaded}, 128'd0);
    check("rm_q0", q0, 128'd0);
    check("rm_csum", {96'd0, checksum}, 128'd0);
    tick();
    rst = 1'b1;
    tick();
    check("rm_idle_ready", {127'd0, data_in_ready}, 128'd0);
    read_word(0, rv);
    check("rm_retained", rv, exp_word(100, 0));
    pulse_start();
    send_beats(0, 0, 8, 1'b0);
    check("rm_reload_done", {127'd0, load_done}, 128'd1);
    check("rm_reload_csum", {96'd0, checksum}, {96'd0, exp_csum});
    check_ram("rm_reload", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
